dma_arbiter: RTL and testbench

- N-requester arbiter in front of the single shared DMA port.
- Replaces the hand-wired OR/mux of load_block and cnn_controller onto the DMA (dmaEnable / readWrite / dmaAddress).
- Grants one requester per transaction (round-robin or fixed priority) and latches its command.
- Drives the DMA for a fixed access latency, then returns a one-cycle done to the granted requester.

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_arbiter_rr_pick.sv | 40 ++++
 rtl/dma_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dma_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: definitions shared by the DMA arbiter slice.
// Holds the arbiter state encoding, the DMA direction constants and the
// default DMA address/data widths.
package dma_pkg;

  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 16;

  // Direction encoding on the DMA rw line
  localparam logic DMA_READ  = 1'b1;
  localparam logic DMA_WRITE = 1'b0;

  // Arbiter state encoding (plain constants so older tools can consume it)
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_BUSY = 2'd1;
  localparam arb_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/dma_arbiter_rr_pick.sv
// rr_pick: combinational wrap-around priority picker.
// Scans req_i starting at index ptr_i and moving upward, wrapping from
// NUM_REQ-1 back to 0, and reports the first set request.
// Ports:
//   req_i     - request vector
//   ptr_i     - index with highest priority this cycle
//   onehot_o  - one-hot winner (all zero when no request)
//   idx_o     - winner index (0 when no request)
//   valid_o   - at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] scan;

  // The first hit along the rotated scan order wins; later hits are masked
  // by valid_o so the result is always one-hot.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    scan     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[scan]) begin
        valid_o        = 1'b1;
        onehot_o[scan] = 1'b1;
        idx_o          = scan;
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: N-requester arbiter in front of the single shared DMA port.
// Grants one requester per transaction, latches its command, holds
// dma_enable for DMA_LAT cycles, then pulses done to that requester.
// Ports:
//   clk_i, rst_ni         - clock (rising edge), async active-low reset
//   req_i, rw_i          - per-requester request level and direction
//   addr_i, wdata_i      - flattened per-requester address / write data
//   gnt_o, done_o        - one-hot grant and one-cycle completion pulse
//   dma_enable_o, dma_rw_o, dma_addr_o, dma_wdata_o - DMA command
//   busy_o               - arbiter is not idle
module dma_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter bit RR_MODE = 1'b1,
  parameter int DMA_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        rw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      dma_enable_o,
  output logic                      dma_rw_o,
  output logic [ADDR_W-1:0]         dma_addr_o,
  output logic [DATA_W-1:0]         dma_wdata_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DMA_LAT + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               en_q, en_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_ptr;

  // Fixed priority is the round-robin picker pinned to start at index 0.
  assign pick_ptr = RR_MODE ? rr_ptr_q : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Next-state logic. The command is captured only on the IDLE->BUSY
  // transition, so requester inputs are ignored for the rest of the
  // transaction. done is a default-zero pulse that exists only in DONE.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    en_d     = en_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_BUSY;
          idx_d   = pick_idx;
          gnt_d   = pick_onehot;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(DMA_LAT - 1);
          rw_d    = rw_i[pick_idx];
          addr_d  = addr_i[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = wdata_i[pick_idx*DATA_W +: DATA_W];
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        // Rotate priority past the requester just served
        if (RR_MODE) begin
          rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      en_q     <= en_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign dma_enable_o = en_q;
  assign dma_rw_o     = rw_q;
  assign dma_addr_o   = addr_q;
  assign dma_wdata_o  = wdata_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed self-checking bench for dma_arbiter.
// Four instances share clock and reset:
//   A: round-robin, DMA_LAT=1     B: fixed priority, DMA_LAT=1 (same inputs as A)
//   C: round-robin, DMA_LAT=4     D: round-robin, DMA_LAT=3
module tb_dma_arbiter;
  import dma_pkg::*;

  logic clk;
  logic rst_n;

  // Stimulus for instances A and B
  logic [1:0]  reqAB, rwAB;
  logic [31:0] addrAB, wdataAB;
  // Stimulus for instance C
  logic [1:0]  reqC, rwC;
  logic [31:0] addrC, wdataC;
  // Stimulus for instance D
  logic [1:0]  reqD, rwD;
  logic [31:0] addrD, wdataD;

  logic [1:0]  gntA, doneA, gntB, doneB, gntC, doneC, gntD, doneD;
  logic        enA, enB, enC, enD;
  logic        rwOutA, rwOutB, rwOutC, rwOutD;
  logic [15:0] addrOutA, addrOutB, addrOutC, addrOutD;
  logic [15:0] wdataOutA, wdataOutB, wdataOutC, wdataOutD;
  logic        busyA, busyB, busyC, busyD;

  int checks;
  int failures;

  dma_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(1'b1), .DMA_LAT(1)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqAB), .rw_i(rwAB), .addr_i(addrAB),
    .wdata_i(wdataAB), .gnt_o(gntA), .done_o(doneA), .dma_enable_o(enA),
    .dma_rw_o(rwOutA), .dma_addr_o(addrOutA), .dma_wdata_o(wdataOutA), .busy_o(busyA));

  dma_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(1'b0), .DMA_LAT(1)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqAB), .rw_i(rwAB), .addr_i(addrAB),
    .wdata_i(wdataAB), .gnt_o(gntB), .done_o(doneB), .dma_enable_o(enB),
    .dma_rw_o(rwOutB), .dma_addr_o(addrOutB), .dma_wdata_o(wdataOutB), .busy_o(busyB));

  dma_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(1'b1), .DMA_LAT(4)) dutC (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqC), .rw_i(rwC), .addr_i(addrC),
    .wdata_i(wdataC), .gnt_o(gntC), .done_o(doneC), .dma_enable_o(enC),
    .dma_rw_o(rwOutC), .dma_addr_o(addrOutC), .dma_wdata_o(wdataOutC), .busy_o(busyC));

  dma_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(1'b1), .DMA_LAT(3)) dutD (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqD), .rw_i(rwD), .addr_i(addrD),
    .wdata_i(wdataD), .gnt_o(gntD), .done_o(doneD), .dma_enable_o(enD),
    .dma_rw_o(rwOutD), .dma_addr_o(addrOutD), .dma_wdata_o(wdataOutD), .busy_o(busyD));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the shared A/B requester inputs
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] rw,
                               input logic [31:0] addr, input logic [31:0] wdata);
    reqAB   = req;
    rwAB    = rw;
    addrAB  = addr;
    wdataAB = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected round-robin order for A once its pointer sits at 1
  logic [1:0] rrOrder [4];

  initial begin
    checks   = 0;
    failures = 0;
    rrOrder  = '{2'b10, 2'b01, 2'b10, 2'b01};
    rst_n    = 1'b0;
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
    reqC = '0; rwC = '0; addrC = '0; wdataC = '0;
    reqD = '0; rwD = '0; addrD = '0; wdataD = '0;

    // ---- Reset state ----
    #2;
    checkOutput("rst.gntA",  32'(gntA),     0);
    checkOutput("rst.doneA", 32'(doneA),    0);
    checkOutput("rst.enA",   32'(enA),      0);
    checkOutput("rst.busyA", 32'(busyA),    0);
    checkOutput("rst.addrA", 32'(addrOutA), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---- Single read request from requester 0 ----
    applyStimulus(2'b01, 2'b01, {16'd0, 16'd100}, 32'h0);
    tick();
    checkOutput("t1.gntA",  32'(gntA),     32'h1);
    checkOutput("t1.enA",   32'(enA),      1);
    checkOutput("t1.addrA", 32'(addrOutA), 100);
    checkOutput("t1.rwA",   32'(rwOutA),   32'(DMA_READ));
    checkOutput("t1.busyA", 32'(busyA),    1);
    checkOutput("t1.doneA", 32'(doneA),    0);
    tick();
    checkOutput("t1.doneA2", 32'(doneA), 32'h1);
    checkOutput("t1.enA2",   32'(enA),   0);
    checkOutput("t1.gntA2",  32'(gntA),  32'h1);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    checkOutput("t1.idleGnt",  32'(gntA),  0);
    checkOutput("t1.idleBusy", 32'(busyA), 0);
    checkOutput("t1.idleDone", 32'(doneA), 0);
    tick();
    checkOutput("t1.stillIdle", 32'(busyA), 0);

    // ---- Both requesting, held: A alternates (pointer now 1), B starves req 1 ----
    applyStimulus(2'b11, 2'b00, {16'd22, 16'd11}, {16'hBBBB, 16'hAAAA});
    for (int t = 0; t < 4; t++) begin
      tick();
      checkOutput($sformatf("rr%0d.gntA", t), 32'(gntA), 32'(rrOrder[t]));
      checkOutput($sformatf("rr%0d.addrA", t), 32'(addrOutA),
                  (rrOrder[t] == 2'b01) ? 32'd11 : 32'd22);
      checkOutput($sformatf("fp%0d.gntB", t), 32'(gntB), 32'h1);
      checkOutput($sformatf("fp%0d.wdataB", t), 32'(wdataOutB), 32'hAAAA);
      tick();
      checkOutput($sformatf("rr%0d.doneA", t), 32'(doneA), 32'(rrOrder[t]));
      checkOutput($sformatf("fp%0d.doneB", t), 32'(doneB), 32'h1);
      tick();
      checkOutput($sformatf("rr%0d.idleA", t), 32'(busyA), 0);
      checkOutput($sformatf("fp%0d.idleB", t), 32'(gntB), 0);
    end
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
    tick();

    // ---- Reset asserted mid-BUSY on A (its pointer is 1 now) ----
    applyStimulus(2'b01, 2'b01, {16'd0, 16'd300}, 32'h0);
    tick();
    checkOutput("rb.gntA", 32'(gntA), 32'h1);
    checkOutput("rb.enA",  32'(enA),  1);
    rst_n = 1'b0;
    #1;
    checkOutput("rb.asyncGnt",  32'(gntA),     0);
    checkOutput("rb.asyncEn",   32'(enA),      0);
    checkOutput("rb.asyncBusy", 32'(busyA),    0);
    checkOutput("rb.asyncAddr", 32'(addrOutA), 0);
    tick();
    checkOutput("rb.noDone", 32'(doneA), 0);
    rst_n = 1'b1;
    // Pointer must be back at 0: requester 0 wins a tie
    applyStimulus(2'b11, 2'b00, {16'd2, 16'd1}, 32'h0);
    tick();
    checkOutput("rb.tieGntA", 32'(gntA), 32'h1);
    tick();
    checkOutput("rb.tieDoneA", 32'(doneA), 32'h1);
    applyStimulus(2'b10, 2'b00, {16'd2, 16'd1}, 32'h0);
    tick();
    tick();
    checkOutput("rb.req1GntA",  32'(gntA),     32'h2);
    checkOutput("rb.req1GntB",  32'(gntB),     32'h2);
    checkOutput("rb.req1AddrA", 32'(addrOutA), 2);
    tick();
    checkOutput("rb.req1DoneA", 32'(doneA), 32'h2);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
    tick();

    // ---- C: DMA_LAT=4 write from requester 1, inputs change mid-access ----
    reqC = 2'b10; rwC = 2'b00; addrC = {16'd7, 16'd55}; wdataC = {16'h1234, 16'h9999};
    tick();
    checkOutput("lat4.gnt", 32'(gntC),      32'h2);
    checkOutput("lat4.rw",  32'(rwOutC),    32'(DMA_WRITE));
    checkOutput("lat4.en0", 32'(enC),       1);
    checkOutput("lat4.a0",  32'(addrOutC),  7);
    checkOutput("lat4.w0",  32'(wdataOutC), 32'h1234);
    addrC  = {16'd99, 16'd55};
    wdataC = {16'hFFFF, 16'h9999};
    for (int c = 1; c < 4; c++) begin
      tick();
      checkOutput($sformatf("lat4.en%0d", c),   32'(enC),       1);
      checkOutput($sformatf("lat4.a%0d", c),    32'(addrOutC),  7);
      checkOutput($sformatf("lat4.w%0d", c),    32'(wdataOutC), 32'h1234);
      checkOutput($sformatf("lat4.done%0d", c), 32'(doneC),     0);
    end
    tick();
    checkOutput("lat4.enOff", 32'(enC),   0);
    checkOutput("lat4.done",  32'(doneC), 32'h2);
    reqC = 2'b00;
    tick();
    checkOutput("lat4.idle", 32'(busyC), 0);

    // ---- D: DMA_LAT=3, req[0] dropped one cycle after grant ----
    reqD = 2'b01; rwD = 2'b01; addrD = {16'd0, 16'h40}; wdataD = '0;
    tick();
    checkOutput("drop.gnt", 32'(gntD), 32'h1);
    checkOutput("drop.en0", 32'(enD),  1);
    reqD = 2'b00;
    tick();
    checkOutput("drop.en1",   32'(enD),   1);
    checkOutput("drop.done1", 32'(doneD), 0);
    tick();
    checkOutput("drop.en2",   32'(enD),   1);
    checkOutput("drop.done2", 32'(doneD), 0);
    tick();
    checkOutput("drop.en3",   32'(enD),   0);
    checkOutput("drop.done3", 32'(doneD), 32'h1);
    tick();
    checkOutput("drop.done4", 32'(doneD), 0);
    checkOutput("drop.gnt4",  32'(gntD),  0);
    checkOutput("drop.busy4", 32'(busyD), 0);
    tick();
    checkOutput("drop.noRegrant", 32'(gntD), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
